// File: rtl/stepper_sequencer_if.sv
// Command/status bundle between the motion-command logic (master) and the
// stepper phase sequencer (slave), including the coil drive outputs.
interface stepper_sequencer_if #(
    parameter int DIV_WIDTH   = 16,
    parameter int COUNT_WIDTH = 16,
    parameter int POS_WIDTH   = 32
);
    logic                        start;
    logic                        stop;
    logic                        dir;
    logic                        half_step;
    logic [DIV_WIDTH-1:0]        period;
    logic [COUNT_WIDTH-1:0]      steps;
    logic                        clr_pos;
    logic                        busy;
    logic                        done;
    logic [3:0]                  step_out;
    logic [2:0]                  phase;
    logic signed [POS_WIDTH-1:0] position;

    modport master (
        output start, stop, dir, half_step, period, steps, clr_pos,
        input  busy, done, step_out, phase, position
    );

    modport slave (
        input  start, stop, dir, half_step, period, steps, clr_pos,
        output busy, done, step_out, phase, position
    );
endinterface

// File: rtl/stepper_sequencer.sv
// Stepper-motor phase sequencer: counted half/full-step moves in either
// direction at a programmable rate, with abort and signed position tracking.
module stepper_sequencer #(
    parameter int DIV_WIDTH   = 16,
    parameter int COUNT_WIDTH = 16,
    parameter int POS_WIDTH   = 32,
    parameter bit HOLD_TORQUE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    stepper_sequencer_if.slave bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]                  state_q,     state_d;
    logic [2:0]                  phase_q,     phase_d;
    logic signed [POS_WIDTH-1:0] position_q,  position_d;
    logic                        busy_q,      busy_d;
    logic                        done_q,      done_d;
    logic [3:0]                  step_out_q,  step_out_d;
    logic                        dir_q,       dir_d;
    logic                        half_q,      half_d;
    logic [DIV_WIDTH-1:0]        period_q,    period_d;
    logic [DIV_WIDTH-1:0]        timer_q,     timer_d;
    logic [COUNT_WIDTH-1:0]      remaining_q, remaining_d;

    logic [DIV_WIDTH-1:0] eff_period;
    logic [2:0]           inc;

    function automatic logic [3:0] coil_pattern(input logic [2:0] p);
        case (p)
            3'd0:    coil_pattern = 4'b0001;
            3'd1:    coil_pattern = 4'b0011;
            3'd2:    coil_pattern = 4'b0010;
            3'd3:    coil_pattern = 4'b0110;
            3'd4:    coil_pattern = 4'b0100;
            3'd5:    coil_pattern = 4'b1100;
            3'd6:    coil_pattern = 4'b1000;
            default: coil_pattern = 4'b1001;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        position_d  = position_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dir_d       = dir_q;
        half_d      = half_q;
        period_d    = period_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        eff_period  = (bus.period == '0) ? DIV_WIDTH'(1) : bus.period;
        inc         = half_q ? 3'd1 : 3'd2;

        case (state_q)
            IDLE: begin
                if (bus.clr_pos) begin
                    position_d = '0;
                end
                // stop outranks start here: the request is dropped without a done pulse
                if (bus.start && !bus.stop) begin
                    dir_d    = bus.dir;
                    half_d   = bus.half_step;
                    period_d = eff_period;
                    if (bus.steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = RUN;
                        busy_d      = 1'b1;
                        timer_d     = eff_period;
                        remaining_d = bus.steps;
                    end
                end
            end
            default: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (timer_q == DIV_WIDTH'(1)) begin
                    phase_d     = dir_q ? (phase_q + inc) : (phase_q - inc);
                    position_d  = dir_q ? (position_q + POS_WIDTH'(1)) : (position_q - POS_WIDTH'(1));
                    remaining_d = remaining_q - COUNT_WIDTH'(1);
                    timer_d     = period_q;
                    if (remaining_q == COUNT_WIDTH'(1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - DIV_WIDTH'(1);
                end
            end
        endcase

        // Coil pattern follows the next phase so it lands on the same edge
        step_out_d = ((state_d == RUN) || HOLD_TORQUE) ? coil_pattern(phase_d) : 4'b0000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            position_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            step_out_q  <= 4'b0000;
            dir_q       <= 1'b0;
            half_q      <= 1'b0;
            period_q    <= DIV_WIDTH'(1);
            timer_q     <= DIV_WIDTH'(1);
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            position_q  <= position_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            step_out_q  <= step_out_d;
            dir_q       <= dir_d;
            half_q      <= half_d;
            period_q    <= period_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.step_out = step_out_q;
    assign bus.phase    = phase_q;
    assign bus.position = position_q;

endmodule

// File: tb/tb_stepper_sequencer.sv
// Scoreboard bench for stepper_sequencer: a holding-torque 32-bit-position DUT
// and a no-hold 4-bit-position DUT receive identical commands.
module tb_stepper_sequencer;

    typedef struct {
        int          cyc;
        logic [2:0]  ph;
        logic [3:0]  soA;
        logic [3:0]  soB;
        logic [31:0] pos;
        logic        busy;
    } stepExp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop, dir, halfStep, clrPos;
    logic [15:0] period, steps;

    int          testsRun = 0;
    int          testsFailed = 0;
    int          cyc = 0;
    stepExp_t    stepQ[$];
    int          doneQ[$];
    logic [2:0]  mPhase;
    logic [31:0] mPos;
    bit          monOn = 1'b0;
    logic [2:0]  prevPh = 3'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stepper_sequencer_if #(.DIV_WIDTH(16), .COUNT_WIDTH(16), .POS_WIDTH(32)) ifA ();
    stepper_sequencer_if #(.DIV_WIDTH(16), .COUNT_WIDTH(16), .POS_WIDTH(4))  ifB ();

    assign ifA.start = start;     assign ifB.start = start;
    assign ifA.stop = stop;       assign ifB.stop = stop;
    assign ifA.dir = dir;         assign ifB.dir = dir;
    assign ifA.half_step = halfStep; assign ifB.half_step = halfStep;
    assign ifA.period = period;   assign ifB.period = period;
    assign ifA.steps = steps;     assign ifB.steps = steps;
    assign ifA.clr_pos = clrPos;  assign ifB.clr_pos = clrPos;

    stepper_sequencer #(.DIV_WIDTH(16), .COUNT_WIDTH(16), .POS_WIDTH(32), .HOLD_TORQUE(1'b1)) dutA (
        .clk(clk), .reset(reset), .bus(ifA.slave));
    stepper_sequencer #(.DIV_WIDTH(16), .COUNT_WIDTH(16), .POS_WIDTH(4), .HOLD_TORQUE(1'b0)) dutB (
        .clk(clk), .reset(reset), .bus(ifB.slave));

    function automatic logic [3:0] coilOf(input logic [2:0] p);
        logic [3:0] tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001};
        return tbl[p];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Detect step and done events from the DUT and match them against the scoreboard
    always @(negedge clk) begin
        stepExp_t e;
        int       d;
        if (monOn) begin
            if (ifA.phase !== prevPh) begin
                checkOutput("stepExpected", {63'd0, stepQ.size() != 0}, 64'd1);
                if (stepQ.size() != 0) begin
                    e = stepQ.pop_front();
                    checkOutput("stepCycle", 64'(e.cyc), 64'(cyc));
                    checkOutput("stepPhaseA", {61'd0, ifA.phase}, {61'd0, e.ph});
                    checkOutput("stepPhaseB", {61'd0, ifB.phase}, {61'd0, e.ph});
                    checkOutput("stepOutA", {60'd0, ifA.step_out}, {60'd0, e.soA});
                    checkOutput("stepOutB", {60'd0, ifB.step_out}, {60'd0, e.soB});
                    checkOutput("stepPosA", {32'd0, $unsigned(ifA.position)}, {32'd0, e.pos});
                    checkOutput("stepPosB", {60'd0, $unsigned(ifB.position)}, {60'd0, e.pos[3:0]});
                    checkOutput("stepBusy", {63'd0, ifA.busy}, {63'd0, e.busy});
                end
            end
            if (ifA.done === 1'b1 || ifB.done === 1'b1) begin
                checkOutput("doneExpected", {63'd0, doneQ.size() != 0}, 64'd1);
                if (doneQ.size() != 0) begin
                    d = doneQ.pop_front();
                    checkOutput("doneCycle", 64'(cyc), 64'(d));
                    checkOutput("doneA", {63'd0, ifA.done}, 64'd1);
                    checkOutput("doneB", {63'd0, ifB.done}, 64'd1);
                end
            end
        end
        prevPh = ifA.phase;
    end

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_pendSteps"}, 64'(stepQ.size()), 64'd0);
        checkOutput({tag, "_pendDone"}, 64'(doneQ.size()), 64'd0);
        checkOutput({tag, "_busyA"}, {63'd0, ifA.busy}, 64'd0);
        checkOutput({tag, "_busyB"}, {63'd0, ifB.busy}, 64'd0);
        checkOutput({tag, "_phase"}, {61'd0, ifA.phase}, {61'd0, mPhase});
        checkOutput({tag, "_posA"}, {32'd0, $unsigned(ifA.position)}, {32'd0, mPos});
        checkOutput({tag, "_posB"}, {60'd0, $unsigned(ifB.position)}, {60'd0, mPos[3:0]});
        checkOutput({tag, "_outA"}, {60'd0, ifA.step_out}, {60'd0, coilOf(mPhase)});
        checkOutput({tag, "_outB"}, {60'd0, ifB.step_out}, 64'd0);
    endtask

    // Issue one move; stopAt>0 samples stop at accept edge + stopAt
    task automatic applyStimulus(input string tag, input logic d, input logic h, input logic [15:0] per,
                                 input logic [15:0] n, input int stopAt, input logic clr);
        int       k, p, lastCyc;
        stepExp_t e;
        @(posedge clk); #1;
        k = cyc;
        p = (per == 16'd0) ? 1 : int'(per);
        start = 1'b1; dir = d; halfStep = h; period = per; steps = n; clrPos = clr;
        if (clr) mPos = 32'd0;
        lastCyc = k + 1;
        if (n == 16'd0) begin
            doneQ.push_back(k + 1);
        end else begin
            for (int i = 1; i <= int'(n); i++) begin
                if (stopAt != 0 && i * p >= stopAt) break;
                mPhase = d ? mPhase + (h ? 3'd1 : 3'd2) : mPhase - (h ? 3'd1 : 3'd2);
                mPos   = d ? mPos + 32'd1 : mPos - 32'd1;
                e.cyc  = k + 1 + i * p;
                e.ph   = mPhase;
                e.soA  = coilOf(mPhase);
                e.soB  = (i == int'(n)) ? 4'b0000 : coilOf(mPhase);
                e.busy = (i != int'(n));
                e.pos  = mPos;
                stepQ.push_back(e);
            end
            lastCyc = (stopAt != 0) ? k + 1 + stopAt : k + 1 + int'(n) * p;
            doneQ.push_back(lastCyc);
        end
        @(posedge clk); #1;
        start = 1'b0; clrPos = 1'b0;
        if (stopAt != 0) begin
            while (cyc < k + stopAt) begin @(posedge clk); #1; end
            stop = 1'b1; start = 1'b1;
            @(posedge clk); #1;
            stop = 1'b0; start = 1'b0;
        end
        while (cyc < lastCyc + 2) begin @(posedge clk); #1; end
        checkIdle(tag);
    endtask

    initial begin
        #1000000;
        testsFailed++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0; halfStep = 1'b0;
        period = 16'd0; steps = 16'd0; clrPos = 1'b0;
        mPhase = 3'd0; mPos = 32'd0;
        #2;
        checkOutput("rstPhase", {61'd0, ifA.phase}, 64'd0);
        checkOutput("rstPos", {32'd0, $unsigned(ifA.position)}, 64'd0);
        checkOutput("rstBusy", {63'd0, ifA.busy}, 64'd0);
        checkOutput("rstDone", {63'd0, ifA.done}, 64'd0);
        checkOutput("rstOutA", {60'd0, ifA.step_out}, 64'd0);
        checkOutput("rstOutB", {60'd0, ifB.step_out}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("holdOutA", {60'd0, ifA.step_out}, 64'd1);
        checkOutput("holdOutB", {60'd0, ifB.step_out}, 64'd0);
        @(negedge clk); monOn = 1'b1;

        applyStimulus("halfFwd", 1'b1, 1'b1, 16'd3, 16'd4, 0, 1'b0);
        applyStimulus("fullRev", 1'b0, 1'b0, 16'd1, 16'd3, 0, 1'b0);
        applyStimulus("zeroLen", 1'b1, 1'b1, 16'd5, 16'd0, 0, 1'b0);
        applyStimulus("abortClr", 1'b1, 1'b1, 16'd2, 16'd100, 11, 1'b1);
        checkOutput("abortPos", {32'd0, $unsigned(ifA.position)}, 64'd5);
        applyStimulus("stopAtStep", 1'b0, 1'b1, 16'd3, 16'd10, 6, 1'b0);

        // stop outranks start in IDLE: nothing may happen
        @(posedge clk); #1;
        start = 1'b1; stop = 1'b1; steps = 16'd5; period = 16'd1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        repeat (6) @(posedge clk); #1;
        checkIdle("stopIdle");

        applyStimulus("period0", 1'b1, 1'b0, 16'd0, 16'd3, 0, 1'b0);

        @(posedge clk); #1 clrPos = 1'b1;
        @(posedge clk); #1 clrPos = 1'b0;
        mPos = 32'd0;
        checkIdle("clrPos");
        applyStimulus("toMax", 1'b1, 1'b1, 16'd1, 16'd15, 0, 1'b0);
        applyStimulus("wrap", 1'b1, 1'b1, 16'd1, 16'd1, 0, 1'b0);
        checkOutput("wrapPosB", {60'd0, $unsigned(ifB.position)}, 64'd0);

        // asynchronous reset in the middle of a move
        monOn = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; dir = 1'b1; halfStep = 1'b1; period = 16'd4; steps = 16'd10;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checkOutput("midRstOutA", {60'd0, ifA.step_out}, 64'd0);
        checkOutput("midRstOutB", {60'd0, ifB.step_out}, 64'd0);
        checkOutput("midRstPhase", {61'd0, ifA.phase}, 64'd0);
        checkOutput("midRstBusy", {63'd0, ifA.busy}, 64'd0);
        checkOutput("midRstPos", {32'd0, $unsigned(ifA.position)}, 64'd0);
        mPhase = 3'd0; mPos = 32'd0;
        stepQ.delete(); doneQ.delete();
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk); monOn = 1'b1;
        repeat (6) @(posedge clk); #1;
        checkIdle("afterRst");
        applyStimulus("postRst", 1'b1, 1'b0, 16'd2, 16'd2, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
